// File: rtl/instr_sequencer.sv
// Multi-cycle fetch/execute/mem/writeback sequencer driving a combinational ALU.
// Holds PC, IR, NZCV flags and the result register; all handshake outputs are registered.
module instr_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned PC_STEP  = 4
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_data,
    output logic [3:0]  alu_cond,
    output logic [3:0]  alu_opcode,
    output logic        alu_sbit,
    output logic [2:0]  alu_srcontrol,
    output logic [15:0] alu_imvalue,
    output logic [3:0]  alu_inflags,
    input  logic [31:0] alu_result,
    input  logic [3:0]  alu_outflags,
    output logic [3:0]  rf_raddr1,
    output logic [3:0]  rf_raddr2,
    input  logic [31:0] rf_rdata1,
    input  logic [31:0] rf_rdata2,
    output logic        rf_we,
    output logic [3:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        illegal
);

    typedef enum logic [1:0] {StFetch, StExecute, StMem, StWriteback} state_e;

    localparam logic [31:0] IrReset = 32'h0F00_0000;
    localparam logic [3:0]  OpCmp   = 4'h8;
    localparam logic [3:0]  OpLdr   = 4'h9;
    localparam logic [3:0]  OpStr   = 4'hA;

    state_e      state_q;
    logic [31:0] pc_q;
    logic [31:0] ir_q;
    logic [31:0] result_q;
    logic [3:0]  flags_q;
    logic        imem_req_q;
    logic        dmem_req_q;
    logic        dmem_we_q;
    logic        rf_we_q;
    logic        illegal_q;

    logic [3:0] op;
    logic       flag_n, flag_z, flag_c, flag_v;
    logic       cond_ok;
    logic       is_mem_op;

    assign op                               = ir_q[27:24];
    assign {flag_n, flag_z, flag_c, flag_v} = flags_q;
    assign is_mem_op                        = (op == OpLdr) || (op == OpStr);

    // Same condition table the ALU uses, evaluated on the architectural flags.
    always_comb begin
        cond_ok = 1'b1;
        case (ir_q[31:28])
            4'b0001: cond_ok = flag_z;
            4'b0010: cond_ok = !flag_z && (flag_n == flag_v);
            4'b0011: cond_ok = !flag_z && (flag_n != flag_v);
            4'b0100: cond_ok = (flag_n == flag_v);
            4'b0101: cond_ok = (flag_n != flag_v);
            4'b0110: cond_ok = !flag_z && flag_c;
            4'b0111: cond_ok = !flag_c;
            4'b1000: cond_ok = flag_c;
            default: cond_ok = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StFetch;
            pc_q       <= RESET_PC;
            ir_q       <= IrReset;
            result_q   <= 32'h0;
            flags_q    <= 4'b0000;
            imem_req_q <= 1'b0;
            dmem_req_q <= 1'b0;
            dmem_we_q  <= 1'b0;
            rf_we_q    <= 1'b0;
            illegal_q  <= 1'b0;
        end else begin
            rf_we_q   <= 1'b0;
            illegal_q <= 1'b0;
            case (state_q)
                StFetch: begin
                    if (imem_req_q && imem_ack) begin
                        ir_q       <= imem_data;
                        imem_req_q <= 1'b0;
                        // Flag pulse is timed to coincide with EXECUTE.
                        illegal_q  <= (imem_data[27:24] >= 4'hB) && (imem_data[27:24] <= 4'hE);
                        state_q    <= StExecute;
                    end else begin
                        imem_req_q <= 1'b1;
                    end
                end
                StExecute: begin
                    if (cond_ok) begin
                        if (!op[3]) result_q <= alu_result;
                        if (ir_q[23] || (op == OpCmp)) flags_q <= alu_outflags;
                    end
                    if (cond_ok && is_mem_op) begin
                        dmem_req_q <= 1'b1;
                        dmem_we_q  <= (op == OpStr);
                        state_q    <= StMem;
                    end else begin
                        rf_we_q <= cond_ok && !op[3];
                        state_q <= StWriteback;
                    end
                end
                StMem: begin
                    if (dmem_req_q && dmem_ack) begin
                        if (!dmem_we_q) result_q <= dmem_rdata;
                        rf_we_q    <= !dmem_we_q;
                        dmem_req_q <= 1'b0;
                        dmem_we_q  <= 1'b0;
                        state_q    <= StWriteback;
                    end
                end
                StWriteback: begin
                    pc_q       <= pc_q + 32'(PC_STEP);
                    imem_req_q <= 1'b1;
                    state_q    <= StFetch;
                end
                default: state_q <= StFetch;
            endcase
        end
    end

    assign imem_req      = imem_req_q;
    assign imem_addr     = pc_q;
    assign alu_cond      = ir_q[31:28];
    assign alu_opcode    = ir_q[27:24];
    assign alu_sbit      = ir_q[23];
    assign alu_srcontrol = ir_q[22:20];
    assign alu_imvalue   = ir_q[15:0];
    assign alu_inflags   = flags_q;
    assign rf_raddr1     = ir_q[15:12];
    assign rf_raddr2     = ir_q[11:8];
    assign rf_waddr      = ir_q[19:16];
    assign rf_we         = rf_we_q;
    assign rf_wdata      = result_q;
    assign dmem_req      = dmem_req_q;
    assign dmem_we       = dmem_we_q;
    assign dmem_addr     = rf_rdata1;
    assign dmem_wdata    = rf_rdata2;
    assign illegal       = illegal_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Randomized bench for instr_sequencer: the bench plays imem, dmem, ALU and register file
// and predicts each instruction's effects from the architectural rules.
module tb_instr_sequencer;

    localparam logic [31:0] ResetPc = 32'hFFFF_FFF8;
    localparam int unsigned PcStep  = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req, imem_ack;
    logic [31:0] imem_addr, imem_data;
    logic [3:0]  alu_cond, alu_opcode, alu_inflags, alu_outflags;
    logic        alu_sbit;
    logic [2:0]  alu_srcontrol;
    logic [15:0] alu_imvalue;
    logic [31:0] alu_result;
    logic [3:0]  rf_raddr1, rf_raddr2, rf_waddr;
    logic [31:0] rf_rdata1, rf_rdata2, rf_wdata;
    logic        rf_we;
    logic        dmem_req, dmem_we, dmem_ack, illegal;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] m_pc;
    logic [3:0]  m_flags;

    always #5 clk = ~clk;

    instr_sequencer #(
        .RESET_PC (ResetPc),
        .PC_STEP  (PcStep)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .imem_data     (imem_data),
        .alu_cond      (alu_cond),
        .alu_opcode    (alu_opcode),
        .alu_sbit      (alu_sbit),
        .alu_srcontrol (alu_srcontrol),
        .alu_imvalue   (alu_imvalue),
        .alu_inflags   (alu_inflags),
        .alu_result    (alu_result),
        .alu_outflags  (alu_outflags),
        .rf_raddr1     (rf_raddr1),
        .rf_raddr2     (rf_raddr2),
        .rf_rdata1     (rf_rdata1),
        .rf_rdata2     (rf_rdata2),
        .rf_we         (rf_we),
        .rf_waddr      (rf_waddr),
        .rf_wdata      (rf_wdata),
        .dmem_req      (dmem_req),
        .dmem_we       (dmem_we),
        .dmem_addr     (dmem_addr),
        .dmem_wdata    (dmem_wdata),
        .dmem_ack      (dmem_ack),
        .dmem_rdata    (dmem_rdata),
        .illegal       (illegal)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic bit cond_true(input logic [3:0] cond, input logic [3:0] f);
        bit n, z, c, v;
        {n, z, c, v} = f;
        case (cond)
            4'd1:    return z;
            4'd2:    return !z && (n == v);
            4'd3:    return !z && (n != v);
            4'd4:    return n == v;
            4'd5:    return n != v;
            4'd6:    return !z && c;
            4'd7:    return !c;
            4'd8:    return c;
            default: return 1'b1;
        endcase
    endfunction

    // Runs one instruction from the current negedge; iwait = fetch stall cycles,
    // dwait = data stall cycles before the ack cycle.
    task automatic run_instr(input logic [31:0] instr, input int iwait, input int dwait,
                             input logic [31:0] res, input logic [3:0] oflags,
                             input logic [31:0] rd1, input logic [31:0] rd2,
                             input logic [31:0] ld, input bit noise);
        int          op;
        bit          ok, exp_mem, exp_wr, exp_store, we_seen;
        logic [31:0] exp_wdata, wdata_seen, addr_seen, wd_seen;
        logic [3:0]  exp_flags, waddr_seen;
        int          exp_cycles, exp_ill, cyc, wr, ill, dcyc, to;

        op         = int'(instr[27:24]);
        ok         = cond_true(instr[31:28], m_flags);
        exp_mem    = ok && (op == 9 || op == 10);
        exp_store  = exp_mem && (op == 10);
        exp_wr     = ok && (op < 8 || op == 9);
        exp_wdata  = (op == 9) ? ld : res;
        exp_flags  = (ok && (instr[23] || op == 8)) ? oflags : m_flags;
        exp_cycles = 3 + (exp_mem ? dwait + 1 : 0);
        exp_ill    = (op >= 11 && op <= 14) ? 1 : 0;
        wr = 0; ill = 0; dcyc = 0; to = 0; we_seen = 0;
        wdata_seen = 'x; waddr_seen = 'x; addr_seen = 'x; wd_seen = 'x;

        alu_result = res; alu_outflags = oflags;
        rf_rdata1 = rd1; rf_rdata2 = rd2; dmem_rdata = ld;

        while (!imem_req && to < 20) begin
            @(negedge clk);
            to++;
        end
        check("fetch_req", 32'(imem_req), 32'd1);
        check("imem_addr", imem_addr, m_pc);
        repeat (iwait) begin
            imem_ack = 1'b0;
            @(negedge clk);
        end
        check("req_held", 32'(imem_req), 32'd1);
        imem_ack  = 1'b1;
        imem_data = instr;
        dmem_ack  = noise;
        @(negedge clk);
        cyc      = 1;
        imem_ack = noise;
        dmem_ack = 1'b0;
        check("alu_fields", {alu_cond, alu_opcode, alu_sbit, alu_srcontrol, alu_imvalue},
              {instr[31:20], instr[15:0]});
        check("rf_addrs", {rf_raddr1, rf_raddr2, rf_waddr},
              {instr[15:12], instr[11:8], instr[19:16]});
        check("inflags_exec", alu_inflags, m_flags);

        while (cyc < 40) begin
            if (illegal) ill++;
            if (rf_we) begin
                wr++;
                wdata_seen = rf_wdata;
                waddr_seen = rf_waddr;
            end
            if (dmem_req) begin
                dcyc++;
                we_seen   = we_seen | dmem_we;
                addr_seen = dmem_addr;
                wd_seen   = dmem_wdata;
                dmem_ack  = (dcyc == dwait + 1);
            end else begin
                dmem_ack = 1'b0;
            end
            if (cyc == 2) check("inflags_next", alu_inflags, exp_flags);
            @(negedge clk);
            imem_ack = 1'b0;
            cyc++;
            if (imem_req) break;
        end
        dmem_ack = 1'b0;

        check("cycles", cyc, exp_cycles);
        check("wr_count", wr, exp_wr ? 1 : 0);
        if (exp_wr) begin
            check("wdata", wdata_seen, exp_wdata);
            check("waddr", 32'(waddr_seen), 32'(instr[19:16]));
        end
        check("illegal", ill, exp_ill);
        check("dmem_cycles", dcyc, exp_mem ? dwait + 1 : 0);
        check("dmem_we", 32'(we_seen), 32'(exp_store));
        if (exp_mem) begin
            check("dmem_addr", addr_seen, rd1);
            check("dmem_wdata", wd_seen, rd2);
        end
        m_flags = exp_flags;
        m_pc    = m_pc + PcStep;
        check("pc_next", imem_addr, m_pc);
    endtask

    initial begin
        logic [31:0] instr;
        reset = 1'b1;
        imem_ack = 0; imem_data = 0; dmem_ack = 0; dmem_rdata = 0;
        alu_result = 0; alu_outflags = 0; rf_rdata1 = 0; rf_rdata2 = 0;
        m_pc = ResetPc;
        m_flags = 4'b0000;

        repeat (2) @(negedge clk);
        check("rst_imem_req", 32'(imem_req), 32'd0);
        check("rst_pc", imem_addr, ResetPc);
        check("rst_ir", {alu_cond, alu_opcode}, 32'h0F);
        check("rst_flags", 32'(alu_inflags), 32'd0);
        check("rst_outs", {rf_we, dmem_req, dmem_we, illegal}, 32'd0);
        reset = 1'b0;
        #1 check("req_low_at_release", 32'(imem_req), 32'd0);
        @(negedge clk);
        check("req_one_cycle_after", 32'(imem_req), 32'd1);

        // Directed sequence; PC starts two steps below the wrap point.
        run_instr(32'h0001_2300, 0, 0, 32'd5, 4'b1111, 0, 0, 0, 0);
        run_instr(32'h0181_2300, 0, 0, 32'd0, 4'b0100, 0, 0, 0, 0);
        run_instr(32'h1001_2300, 1, 0, 32'd9, 4'b0000, 0, 0, 0, 1);
        run_instr(32'h0181_2300, 0, 0, 32'd1, 4'b0000, 0, 0, 0, 0);
        run_instr(32'h1001_2300, 0, 0, 32'd7, 4'b1111, 0, 0, 0, 0);
        run_instr(32'h0904_0000, 0, 2, 32'd3, 4'b1010, 32'h100, 32'h0, 32'hDEAD_BEEF, 1);
        run_instr(32'h0A00_1200, 0, 0, 32'd3, 4'b1010, 32'h40, 32'h55, 32'h0, 0);
        run_instr(32'h0C00_0000, 0, 0, 32'd3, 4'b1010, 0, 0, 0, 0);
        run_instr(32'h0800_2300, 0, 0, 32'd0, 4'b0110, 0, 0, 0, 0);

        for (int i = 0; i < 150; i++) begin
            instr = $urandom;
            run_instr(instr, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)), $urandom,
                      4'($urandom), $urandom, $urandom, $urandom, 1'($urandom));
        end

        // Abandon a load in MEM with reset.
        while (!imem_req) @(negedge clk);
        imem_ack = 1'b1; imem_data = 32'h0904_0000; rf_rdata1 = 32'h200;
        @(negedge clk);
        imem_ack = 1'b0;
        @(negedge clk);
        check("mem_req_before_rst", 32'(dmem_req), 32'd1);
        #1 reset = 1'b1;
        #1 check("rst_mid_dmem_req", 32'(dmem_req), 32'd0);
        check("rst_mid_outs", {imem_req, rf_we, dmem_we, illegal}, 32'd0);
        check("rst_mid_pc", imem_addr, ResetPc);
        @(negedge clk);
        reset = 1'b0;
        m_pc = ResetPc;
        m_flags = 4'b0000;
        @(negedge clk);
        check("fetch_after_rst", 32'(imem_req), 32'd1);
        run_instr(32'h0001_2300, 0, 0, 32'd5, 4'b0000, 0, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
